multi_timer: RTL and testbench



---
 rtl/multi_timer_pkg.sv | 39 +++
 rtl/multi_timer_channel.sv | 126 ++++++++++++
 rtl/multi_timer.sv | 117 +++++++++++
 tb/tb_multi_timer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_timer_pkg
// Purpose  : Shared register map and CTRL bit layout for the multi_timer
//            peripheral and its timer_channel sub-block.
// Contents : - OFF_* per-channel register offsets (within a 0x10 window)
//            - ADDR_STATUS global status register address
//            - CTRL_* bit positions and the packed ctrl_t view of CTRL[3:0]
//            - ctrl_word() zero-extends a ctrl_t to a 32-bit bus word
// Revision : 1.0 - initial release
// ============================================================================
package multi_timer_pkg;

    localparam logic [3:0] OFF_CTRL    = 4'h0;
    localparam logic [3:0] OFF_COUNT   = 4'h4;
    localparam logic [3:0] OFF_VALUE   = 4'h8;
    localparam logic [3:0] OFF_PRESC   = 4'hC;
    localparam logic [7:0] ADDR_STATUS = 8'h80;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_PEND = 2;
    localparam int CTRL_MODE = 3;

    // Field order mirrors the CTRL register so the struct casts directly to
    // CTRL[3:0] (mode is the MSB, en the LSB).
    typedef struct packed {
        logic mode;
        logic pend;
        logic ie;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        return {28'd0, c};
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_timer_channel.sv
`default_nettype none
// ============================================================================
// Module   : timer_channel
// Purpose  : One count-up timer channel: CTRL/VALUE/PRESC registers,
//            prescaler, counter and expiry logic.
// Ports    : clk, rstn       - clock, synchronous active-low reset
//            wr_ctrl_i       - write strobe for CTRL
//            wr_value_i      - write strobe for VALUE
//            wr_presc_i      - write strobe for PRESC
//            status_clr_i    - W1C of this channel's bit in STATUS
//            wdata_i[31:0]   - bus write data
//            ctrl_o          - EN/IE/PEND/MODE state
//            count_o, value_o, presc_o - register read-back
//            irq_o           - PEND & IE
// Revision : 1.0 - initial release
// ============================================================================
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int PRE_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wr_ctrl_i,
    input  logic                 wr_value_i,
    input  logic                 wr_presc_i,
    input  logic                 status_clr_i,
    input  logic [31:0]          wdata_i,
    output ctrl_t                ctrl_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic [CNT_WIDTH-1:0] value_o,
    output logic [PRE_WIDTH-1:0] presc_o,
    output logic                 irq_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [PRE_WIDTH-1:0] PRE_ONE = 1;

    ctrl_t                ctrl_q,    ctrl_d;
    logic [CNT_WIDTH-1:0] count_q,   count_d;
    logic [CNT_WIDTH-1:0] value_q,   value_d;
    logic [PRE_WIDTH-1:0] presc_q,   presc_d;
    logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;

    logic tick;
    logic expire;
    logic pend_clr;

    // Only the low CNT_WIDTH/PRE_WIDTH/CTRL bits are stored.
    logic unused_wdata;
    assign unused_wdata = ^wdata_i;

    always_comb begin
        tick     = ctrl_q.en && (pre_cnt_q == presc_q);
        // >= rather than == so a VALUE rewritten below COUNT expires at the
        // next tick instead of wrapping through the full counter range.
        expire   = tick && (count_q >= value_q);
        pend_clr = (wr_ctrl_i && wdata_i[CTRL_PEND]) || status_clr_i;

        ctrl_d    = ctrl_q;
        value_d   = value_q;
        presc_d   = presc_q;
        count_d   = '0;
        pre_cnt_d = '0;

        // A software CTRL write wins over the one-shot auto-disable.
        if (wr_ctrl_i) begin
            ctrl_d.en   = wdata_i[CTRL_EN];
            ctrl_d.ie   = wdata_i[CTRL_IE];
            ctrl_d.mode = wdata_i[CTRL_MODE];
        end else if (expire && !ctrl_q.mode) begin
            ctrl_d.en = 1'b0;
        end

        // A hardware set wins over a same-cycle W1C.
        if (expire) begin
            ctrl_d.pend = 1'b1;
        end else if (pend_clr) begin
            ctrl_d.pend = 1'b0;
        end

        if (wr_value_i) begin
            value_d = wdata_i[CNT_WIDTH-1:0];
        end
        if (wr_presc_i) begin
            presc_d = wdata_i[PRE_WIDTH-1:0];
        end

        // Counters advance only while running now and next cycle; any other
        // case leaves them at 0, which also makes a 0->1 enable start clean.
        if (ctrl_q.en && ctrl_d.en) begin
            if (tick) begin
                pre_cnt_d = '0;
                count_d   = expire ? '0 : (count_q + CNT_ONE);
            end else begin
                pre_cnt_d = pre_cnt_q + PRE_ONE;
                count_d   = count_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            value_q   <= '0;
            presc_q   <= '0;
            pre_cnt_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            value_q   <= value_d;
            presc_q   <= presc_d;
            pre_cnt_q <= pre_cnt_d;
        end
    end

    assign ctrl_o  = ctrl_q;
    assign count_o = count_q;
    assign value_o = value_q;
    assign presc_o = presc_q;
    assign irq_o   = ctrl_q.pend && ctrl_q.ie;

endmodule
`default_nettype wire

// File: rtl/multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_timer
// Purpose  : NUM_CH-channel count-up timer on the simple peripheral bus.
//            Address decode, combinational read mux and interrupt reduction;
//            per-channel state lives in timer_channel.
// Ports    : clk, rstn        - clock, synchronous active-low reset
//            data_i[31:0]     - write data
//            addr_i[31:0]     - byte address, [7:0] decoded
//            we_i             - write strobe
//            data_o[31:0]     - combinational read data (0 while in reset)
//            int_vec_o        - per-channel PEND & IE
//            int_sig_o        - OR of int_vec_o
// Revision : 1.0 - initial release
// ============================================================================
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int CNT_WIDTH = 32,
    parameter int PRE_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       data_i,
    input  logic [31:0]       addr_i,
    input  logic              we_i,
    output logic [31:0]       data_o,
    output logic [NUM_CH-1:0] int_vec_o,
    output logic              int_sig_o
);

    localparam logic [3:0] NUM_CH_W = 4'(NUM_CH);

    logic [7:0] addr_lo;
    logic [2:0] sel_ch;
    logic [3:0] sel_off;
    logic       chan_hit;
    logic       status_hit;

    logic unused_addr;
    assign unused_addr = ^addr_i[31:8];

    assign addr_lo    = addr_i[7:0];
    assign sel_ch     = addr_lo[6:4];
    assign sel_off    = addr_lo[3:0];
    // Channel windows occupy 0x00..0x7F; windows beyond NUM_CH are holes.
    assign chan_hit   = !addr_lo[7] && ({1'b0, sel_ch} < NUM_CH_W);
    assign status_hit = (addr_lo == ADDR_STATUS);

    ctrl_t                ch_ctrl  [NUM_CH];
    logic [CNT_WIDTH-1:0] ch_count [NUM_CH];
    logic [CNT_WIDTH-1:0] ch_value [NUM_CH];
    logic [PRE_WIDTH-1:0] ch_presc [NUM_CH];
    logic [NUM_CH-1:0]    pend_vec;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic this_ch;
            logic wr_ctrl;
            logic wr_value;
            logic wr_presc;
            logic status_clr;

            assign this_ch    = chan_hit && (sel_ch == 3'(c));
            assign wr_ctrl    = we_i && this_ch && (sel_off == OFF_CTRL);
            assign wr_value   = we_i && this_ch && (sel_off == OFF_VALUE);
            assign wr_presc   = we_i && this_ch && (sel_off == OFF_PRESC);
            assign status_clr = we_i && status_hit && data_i[c];

            timer_channel #(
                .CNT_WIDTH (CNT_WIDTH),
                .PRE_WIDTH (PRE_WIDTH)
            ) u_ch (
                .clk          (clk),
                .rstn         (rstn),
                .wr_ctrl_i    (wr_ctrl),
                .wr_value_i   (wr_value),
                .wr_presc_i   (wr_presc),
                .status_clr_i (status_clr),
                .wdata_i      (data_i),
                .ctrl_o       (ch_ctrl[c]),
                .count_o      (ch_count[c]),
                .value_o      (ch_value[c]),
                .presc_o      (ch_presc[c]),
                .irq_o        (int_vec_o[c])
            );

            assign pend_vec[c] = ch_ctrl[c].pend;
        end
    endgenerate

    always_comb begin
        data_o = '0;
        if (rstn) begin
            if (status_hit) begin
                data_o[NUM_CH-1:0] = pend_vec;
            end else if (chan_hit) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (sel_ch == 3'(c)) begin
                        case (sel_off)
                            OFF_CTRL:  data_o = ctrl_word(ch_ctrl[c]);
                            OFF_COUNT: data_o[CNT_WIDTH-1:0] = ch_count[c];
                            OFF_VALUE: data_o[CNT_WIDTH-1:0] = ch_value[c];
                            OFF_PRESC: data_o[PRE_WIDTH-1:0] = ch_presc[c];
                            default:   data_o = '0;
                        endcase
                    end
                end
            end
        end
    end

    assign int_sig_o = |int_vec_o;

endmodule
`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_timer
// Purpose  : Self-checking bench for multi_timer (NUM_CH=2). A behavioural
//            model tracks each channel's registers and phase; every cycle the
//            bus outputs are compared against it, and directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_timer;

    localparam int NCH = 2;
    localparam int CW  = 32;
    localparam int PW  = 16;
    localparam longint unsigned CW_MASK = (64'd1 << CW) - 1;
    localparam longint unsigned PW_MASK = (64'd1 << PW) - 1;

    logic           clk    = 1'b0;
    logic           rstn   = 1'b0;
    logic [31:0]    data_i = '0;
    logic [31:0]    addr_i = '0;
    logic           we_i   = 1'b0;
    logic [31:0]    data_o;
    logic [NCH-1:0] int_vec_o;
    logic           int_sig_o;

    always #5 clk = ~clk;

    multi_timer #(
        .NUM_CH    (NCH),
        .CNT_WIDTH (CW),
        .PRE_WIDTH (PW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .data_i    (data_i),
        .addr_i    (addr_i),
        .we_i      (we_i),
        .data_o    (data_o),
        .int_vec_o (int_vec_o),
        .int_sig_o (int_sig_o)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0]    rd_last;
    logic [NCH-1:0] vec_last;
    logic           sig_last;

    // Behavioural model: phase = cycles since the last tick (or enable).
    bit              m_en   [NCH];
    bit              m_ie   [NCH];
    bit              m_pend [NCH];
    bit              m_mode [NCH];
    longint unsigned m_cnt  [NCH];
    longint unsigned m_val  [NCH];
    longint unsigned m_presc[NCH];
    longint unsigned m_phase[NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a_full);
        logic [7:0] a;
        int         c;
        logic [31:0] r;
        a = a_full[7:0];
        r = '0;
        if (!rstn) return r;
        if (a == 8'h80) begin
            for (int k = 0; k < NCH; k++) r[k] = m_pend[k];
            return r;
        end
        if (a >= 8'h80) return r;
        c = int'(a) / 16;
        if (c >= NCH) return r;
        case (a[3:0])
            4'h0:    r = {28'd0, m_mode[c], m_pend[c], m_ie[c], m_en[c]};
            4'h4:    r = 32'(m_cnt[c]);
            4'h8:    r = 32'(m_val[c]);
            4'hC:    r = 32'(m_presc[c]);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic bit will_expire(input int c);
        return m_en[c] && (m_phase[c] == m_presc[c]) && (m_cnt[c] >= m_val[c]);
    endfunction

    task automatic model_step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        bit wc, wv, wp, clr, tick, expd, run_next;
        if (!r) begin
            for (int c = 0; c < NCH; c++) begin
                m_en[c] = 0; m_ie[c] = 0; m_pend[c] = 0; m_mode[c] = 0;
                m_cnt[c] = 0; m_val[c] = 0; m_presc[c] = 0; m_phase[c] = 0;
            end
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            wc   = w && (int'(a[7:0]) == c * 16);
            wv   = w && (int'(a[7:0]) == c * 16 + 8);
            wp   = w && (int'(a[7:0]) == c * 16 + 12);
            clr  = w && (a[7:0] == 8'h80) && d[c];
            tick = m_en[c] && (m_phase[c] == m_presc[c]);
            expd = tick && (m_cnt[c] >= m_val[c]);
            if (wc)                        run_next = d[0];
            else if (expd && !m_mode[c])   run_next = 0;
            else                           run_next = m_en[c];
            if (m_en[c] && run_next) begin
                if (tick) begin
                    m_phase[c] = 0;
                    m_cnt[c]   = expd ? 0 : m_cnt[c] + 1;
                end else begin
                    m_phase[c] = m_phase[c] + 1;
                end
            end else begin
                m_phase[c] = 0;
                m_cnt[c]   = 0;
            end
            if (expd)                          m_pend[c] = 1;
            else if ((wc && d[2]) || clr)      m_pend[c] = 0;
            if (wc) begin
                m_ie[c]   = d[1];
                m_mode[c] = d[3];
            end
            m_en[c] = run_next;
            if (wv) m_val[c]   = longint'(d) & CW_MASK;
            if (wp) m_presc[c] = longint'(d) & PW_MASK;
        end
    endtask

    // One bus cycle: drive, compare all outputs against the model, clock.
    task automatic do_cycle(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        logic [NCH-1:0] ev;
        rstn   = r;
        we_i   = w;
        addr_i = a;
        data_i = d;
        #1;
        for (int c = 0; c < NCH; c++) ev[c] = m_pend[c] & m_ie[c];
        check("data_o", data_o, model_read(a));
        check("int_vec_o", 32'(int_vec_o), 32'(ev));
        check("int_sig_o", 32'(int_sig_o), 32'(|ev));
        rd_last  = data_o;
        vec_last = int_vec_o;
        sig_last = int_sig_o;
        @(posedge clk);
        model_step(r, w, a, d);
        #2;
    endtask

    logic [31:0] addr_tab [14] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
                                   32'h1C, 32'h20, 32'h2C, 32'h80, 32'h84, 32'h02, 32'hFF};

    initial begin
        bit found;
        logic [31:0] a, d;

        @(posedge clk);
        #2;

        // Reset held: data_o forced 0 whatever the address.
        repeat (4) do_cycle(0, 1, $urandom, $urandom);
        for (int k = 0; k <= 32'h8C; k += 4) begin
            do_cycle(1, 0, 32'(k), 0);
            check("reset_read", rd_last, 0);
        end

        // Writes to a nonexistent channel change nothing.
        do_cycle(1, 1, 32'h20, 32'hF);
        do_cycle(1, 1, 32'h28, 32'h5);
        do_cycle(1, 1, 32'h2C, 32'h1);
        for (int k = 0; k <= 32'h8C; k += 4) begin
            do_cycle(1, 0, 32'(k), 0);
            check("hole_write_read", rd_last, 0);
        end

        // Ch0 one-shot: VALUE=5, PRESC=0 -> PEND 6 edges after the CTRL write.
        do_cycle(1, 1, 32'h08, 5);
        do_cycle(1, 1, 32'h0C, 0);
        do_cycle(1, 1, 32'h00, 3);
        for (int j = 1; j <= 7; j++) begin
            do_cycle(1, 0, 32'h80, 0);
            if (j == 6) check("ch0_pend_early", rd_last, 0);
            if (j == 7) begin
                check("ch0_pend_on_time", rd_last, 1);
                check("ch0_int_sig", 32'(sig_last), 1);
            end
        end
        do_cycle(1, 0, 32'h00, 0);
        check("ch0_ctrl_oneshot", rd_last, 32'h6);
        do_cycle(1, 0, 32'h04, 0);
        check("ch0_count_after", rd_last, 0);

        // Ch1 periodic: VALUE=3, PRESC=2 -> 12-edge period.
        do_cycle(1, 1, 32'h00, 32'h4);
        do_cycle(1, 1, 32'h18, 3);
        do_cycle(1, 1, 32'h1C, 2);
        do_cycle(1, 1, 32'h10, 32'hB);
        for (int j = 1; j <= 13; j++) begin
            do_cycle(1, 0, 32'h80, 0);
            if (j == 12) check("ch1_pend_early", rd_last, 0);
            if (j == 13) check("ch1_pend_on_time", rd_last, 2);
        end
        do_cycle(1, 1, 32'h80, 2);
        for (int k = 1; k <= 11; k++) begin
            do_cycle(1, 0, 32'h80, 0);
            if (k == 1)  check("ch1_w1c", rd_last, 0);
            if (k == 10) check("ch1_period2_early", rd_last, 0);
            if (k == 11) check("ch1_period2", rd_last, 2);
        end
        do_cycle(1, 0, 32'h10, 0);
        check("ch1_ctrl_periodic", rd_last, 32'hF);

        // Both pending, only ch1 has IE.
        do_cycle(1, 1, 32'h00, 32'h9);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            do_cycle(1, 0, 32'h80, 0);
            if (rd_last == 3) found = 1;
        end
        check("both_pend_seen", 32'(found), 1);
        check("both_int_vec", 32'(vec_last), 32'h2);
        check("both_int_sig", 32'(sig_last), 1);

        // CTRL PEND clear in the same cycle as a ch1 expiry.
        do_cycle(1, 1, 32'h80, 3);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (will_expire(1)) found = 1;
            else do_cycle(1, 0, 32'h80, 0);
        end
        check("race_expiry_found", 32'(found), 1);
        do_cycle(1, 1, 32'h10, 32'hF);
        do_cycle(1, 0, 32'h80, 0);
        check("race_pend_kept", 32'(rd_last[1]), 1);

        // Ch0 at COUNT=10, VALUE lowered to 4 -> expiry on the following tick.
        do_cycle(1, 1, 32'h00, 32'h4);
        do_cycle(1, 1, 32'h08, 20);
        do_cycle(1, 1, 32'h00, 32'h9);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_cnt[0] == 10) found = 1;
            else do_cycle(1, 0, 32'h04, 0);
        end
        check("count10_found", 32'(found), 1);
        do_cycle(1, 1, 32'h08, 4);
        do_cycle(1, 0, 32'h04, 0);
        check("lowval_count11", rd_last, 11);
        do_cycle(1, 0, 32'h04, 0);
        check("lowval_count0", rd_last, 0);
        do_cycle(1, 0, 32'h80, 0);
        check("lowval_pend", 32'(rd_last[0]), 1);

        // Mid-count reset clears everything; nothing resumes by itself.
        do_cycle(0, 0, 32'h04, 0);
        for (int k = 0; k <= 32'h1C; k += 4) begin
            do_cycle(1, 0, 32'(k), 0);
            check("midreset_read", rd_last, 0);
        end
        do_cycle(1, 0, 32'h80, 0);
        check("midreset_status", rd_last, 0);
        check("midreset_int_sig", 32'(sig_last), 0);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            a = addr_tab[$urandom_range(0, 13)];
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FF00);
            case (a[3:0])
                4'h0:    d = 32'($urandom_range(0, 15)) | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
                4'h8:    d = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 12));
                4'hC:    d = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 3));
                default: d = $urandom;
            endcase
            do_cycle(($urandom_range(0, 499) != 0), ($urandom_range(0, 2) == 0), a, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
